// File: rtl/register_file_8x32_pkg.sv
// Shared constants and helpers for the 8-entry register file.
// Holds the register count, address width, default data width and the one-hot check.
package register_file_8x32_pkg;

  localparam int NUM_REGS       = 8;
  localparam int ADDR_W         = 3;
  localparam int DEFAULT_DATA_W = 32;

  // A write select is usable only when exactly one register is targeted.
  function automatic logic is_one_hot(input logic [NUM_REGS-1:0] sel);
    return (sel != '0) && ((sel & (sel - NUM_REGS'(1))) == '0);
  endfunction

endpackage

// File: rtl/register_file_8x32_reg_cell.sv
// One storage word of the register file: a DATA_W-bit register with load enable
// and synchronous active-low clear.
module reg_cell
  import register_file_8x32_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_8x32.sv
// Eight-register file with a one-hot write select, two combinational read ports,
// optional same-cycle write forwarding, a sticky bad-select flag and a write counter.
module register_file_8x32
  import register_file_8x32_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [NUM_REGS-1:0] wsel,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                sel_err,
  output logic [7:0]          wr_count
);

  logic                             sel_valid;
  logic                             write_commit;
  logic [NUM_REGS-1:0][DATA_W-1:0]  reg_q;
  logic                             sel_err_reg;
  logic [7:0]                       wr_count_reg;

  assign sel_valid = is_one_hot(wsel);
  // Reset wins over a write, so a write in a reset cycle is neither stored nor forwarded.
  assign write_commit = reset_n && we && sel_valid;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
      reg_cell #(
        .DATA_W (DATA_W)
      ) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (write_commit && wsel[gi]),
        .d       (wdata),
        .q       (reg_q[gi])
      );
    end
  endgenerate

  always_comb begin
    rdata_a = reg_q[raddr_a];
    rdata_b = reg_q[raddr_b];
    if (BYPASS != 0) begin
      if (write_commit && wsel[raddr_a]) rdata_a = wdata;
      if (write_commit && wsel[raddr_b]) rdata_b = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err_reg  <= 1'b0;
      wr_count_reg <= 8'd0;
    end else if (we) begin
      if (sel_valid) begin
        wr_count_reg <= wr_count_reg + 8'd1;
      end else begin
        sel_err_reg <= 1'b1;
      end
    end
  end

  assign sel_err  = sel_err_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_register_file_8x32.sv
// Bench for register_file_8x32: a forwarding and a non-forwarding instance share stimulus,
// an array model is compared every cycle, and directed vectors pin literal results.
module tb_register_file_8x32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [7:0]  wsel;
  logic [31:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [31:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;
  logic        sel_err1, sel_err0;
  logic [7:0]  wr_count1, wr_count0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_8x32 #(.DATA_W(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset_n(reset_n), .we(we), .wsel(wsel), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
    .sel_err(sel_err1), .wr_count(wr_count1)
  );

  register_file_8x32 #(.DATA_W(32), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset_n(reset_n), .we(we), .wsel(wsel), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
    .sel_err(sel_err0), .wr_count(wr_count0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: plain array of words, a flag and a count.
  logic [31:0] m_regs [8];
  logic        m_err;
  int          m_count;
  bit          model_ok = 0;

  function automatic bit m_commit();
    return reset_n && we && ($countones(wsel) == 1);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      m_err    = 1'b0;
      m_count  = 0;
      model_ok = 1;
    end else if (model_ok && we) begin
      if ($countones(wsel) == 1) begin
        for (int i = 0; i < 8; i++) if (wsel[i]) m_regs[i] = wdata;
        m_count = (m_count + 1) % 256;
      end else begin
        m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] ea, eb;
      ea = (m_commit() && wsel[raddr_a]) ? wdata : m_regs[raddr_a];
      eb = (m_commit() && wsel[raddr_b]) ? wdata : m_regs[raddr_b];
      check("cmp_rdata_a_byp", rdata_a1, ea);
      check("cmp_rdata_b_byp", rdata_b1, eb);
      check("cmp_rdata_a_nobyp", rdata_a0, m_regs[raddr_a]);
      check("cmp_rdata_b_nobyp", rdata_b0, m_regs[raddr_b]);
      check("cmp_sel_err", {30'd0, sel_err1, sel_err0}, {30'd0, m_err, m_err});
      check("cmp_wr_count_byp", {24'd0, wr_count1}, 32'(m_count));
      check("cmp_wr_count_nobyp", {24'd0, wr_count0}, 32'(m_count));
    end
  end

  // One transaction per clock; directed checks run 3 time units after the edge.
  task automatic step(input logic rn, input logic w, input logic [7:0] ws,
                      input logic [31:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    @(posedge clk);
    #1;
    reset_n = rn; we = w; wsel = ws; wdata = wd; raddr_a = ra; raddr_b = rb;
    $display("txn reset_n=%0b we=%0b wsel=%h wdata=%h ra=%0d rb=%0d", rn, w, ws, wd, ra, rb);
    #2;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; wsel = 8'h00; wdata = 32'd0; raddr_a = 3'd0; raddr_b = 3'd0;
    step(0, 0, 8'h00, 32'd0, 3'd0, 3'd0);
    step(0, 0, 8'h00, 32'd0, 3'd0, 3'd0);

    // Everything reads zero after reset.
    for (int a = 0; a < 8; a++) begin
      step(1, 0, 8'h00, 32'd0, 3'(a), 3'(7 - a));
      check("rst_rdata_a", rdata_a1, 32'd0);
      check("rst_rdata_b", rdata_b0, 32'd0);
    end
    check("rst_sel_err", {31'd0, sel_err1}, 32'd0);
    check("rst_wr_count", {24'd0, wr_count0}, 32'd0);

    // Basic write then read back.
    step(1, 1, 8'h08, 32'hDEADBEEF, 3'd0, 3'd0);
    step(1, 0, 8'h00, 32'd0, 3'd3, 3'd3);
    check("wr_r3_rdata_a", rdata_a1, 32'hDEADBEEF);
    check("wr_r3_rdata_b_nobyp", rdata_b0, 32'hDEADBEEF);
    check("wr_r3_count", {24'd0, wr_count1}, 32'd1);
    check("model_r3", m_regs[3], 32'hDEADBEEF);

    // Same-cycle forwarding versus none.
    step(1, 1, 8'h20, 32'h12345678, 3'd0, 3'd5);
    check("bypass_rdata_b", rdata_b1, 32'h12345678);
    check("nobypass_rdata_b", rdata_b0, 32'd0);
    step(1, 0, 8'h00, 32'd0, 3'd5, 3'd5);
    check("after_edge_rdata_a", rdata_a0, 32'h12345678);
    check("after_edge_rdata_b", rdata_b1, 32'h12345678);
    check("after_edge_count", {24'd0, wr_count0}, 32'd2);

    // Invalid selects: multi-hot and all-zero.
    step(1, 1, 8'h04, 32'h00000022, 3'd0, 3'd0);
    step(1, 1, 8'h0C, 32'hFFFFFFFF, 3'd2, 3'd3);
    check("multihot_no_bypass_a", rdata_a1, 32'h00000022);
    check("multihot_no_bypass_b", rdata_b1, 32'hDEADBEEF);
    check("multihot_err_not_yet", {31'd0, sel_err1}, 32'd0);
    step(1, 0, 8'h00, 32'd0, 3'd2, 3'd3);
    check("multihot_r2_kept", rdata_a1, 32'h00000022);
    check("multihot_r3_kept", rdata_b0, 32'hDEADBEEF);
    check("multihot_err_set", {31'd0, sel_err0}, 32'd1);
    check("multihot_count_kept", {24'd0, wr_count1}, 32'd3);
    step(1, 1, 8'h00, 32'h0000AAAA, 3'd0, 3'd2);
    check("zero_sel_no_bypass", rdata_a1, 32'd0);
    step(1, 0, 8'hFF, 32'h00005555, 3'd0, 3'd0);
    check("we0_ignored_r0", rdata_a1, 32'd0);
    step(1, 0, 8'h00, 32'd0, 3'd0, 3'd0);
    check("err_sticky", {31'd0, sel_err1}, 32'd1);
    check("we0_count_kept", {24'd0, wr_count0}, 32'd3);
    check("model_err", {31'd0, m_err}, 32'd1);

    // Reset beats a simultaneous write.
    step(0, 1, 8'h80, 32'd5, 3'd7, 3'd7);
    step(1, 0, 8'h00, 32'd0, 3'd7, 3'd7);
    check("rst_prio_r7", rdata_a1, 32'd0);
    check("rst_prio_count", {24'd0, wr_count1}, 32'd0);
    check("rst_prio_err", {31'd0, sel_err0}, 32'd0);
    check("model_count_rst", 32'(m_count), 32'd0);

    // Counter wrap.
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 8'(1 << (i % 8)), 32'(i), 3'(i % 8), 3'((i + 1) % 8));
    end
    step(1, 0, 8'h00, 32'd0, 3'd7, 3'd0);
    check("wrap_count_byp", {24'd0, wr_count1}, 32'd0);
    check("wrap_count_nobyp", {24'd0, wr_count0}, 32'd0);
    check("wrap_r7", rdata_a1, 32'd255);
    check("wrap_r0", rdata_b0, 32'd248);
    step(1, 1, 8'h01, 32'h0BADF00D, 3'd0, 3'd1);
    step(1, 0, 8'h00, 32'd0, 3'd0, 3'd0);
    check("wrap_plus1_count", {24'd0, wr_count1}, 32'd1);
    check("wrap_plus1_r0", rdata_a0, 32'h0BADF00D);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
